// File: rtl/load_store_unit.sv
// Data-memory access stage: turns one load/store request into a word-aligned,
// byte-enabled memory transaction and returns the lane-extracted load result.
module load_store_unit #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_data,
    output logic        done,
    output logic        misaligned,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam bit         LP_TIMEOUT_EN = (ACK_TIMEOUT != 0);
    localparam logic [7:0] LP_LAST_CNT   = 8'(ACK_TIMEOUT - 1);

    state_t      r_state;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [1:0]  r_offset;
    logic [7:0]  r_cnt;
    logic        r_req_ready;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_load_data;
    logic        r_done;
    logic        r_misaligned;
    logic        r_bus_error;

    logic        w_fault;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rshift;
    logic [31:0] w_load_ext;

    // Request decode: alignment/encoding check, byte enables and store lanes.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case statements can leave it unassigned and infer a latch.
        w_fault = 1'b0;
        w_be    = 4'b1111;
        case (req_funct3)
            3'b000:  w_fault = 1'b0;
            3'b001:  w_fault = req_addr[0];
            3'b010:  w_fault = |req_addr[1:0];
            3'b100:  w_fault = req_write;
            3'b101:  w_fault = req_write | req_addr[0];
            default: w_fault = 1'b1;
        endcase
        if (req_write) begin
            case (req_funct3[1:0])
                2'b00:   w_be = 4'b0001 << req_addr[1:0];
                2'b01:   w_be = 4'b0011 << req_addr[1:0];
                default: w_be = 4'b1111;
            endcase
        end
    end

    assign w_wdata  = req_wdata << {req_addr[1:0], 3'b000};
    assign w_rshift = mem_rdata >> {r_offset, 3'b000};

    always_comb begin
        w_load_ext = w_rshift;
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_rshift[7]}}, w_rshift[7:0]};
            3'b001:  w_load_ext = {{16{w_rshift[15]}}, w_rshift[15:0]};
            3'b100:  w_load_ext = {24'd0, w_rshift[7:0]};
            3'b101:  w_load_ext = {16'd0, w_rshift[15:0]};
            default: w_load_ext = w_rshift;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_funct3     <= 3'd0;
            r_offset     <= 2'd0;
            r_cnt        <= 8'd0;
            r_req_ready  <= 1'b1;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_be     <= 4'd0;
            r_mem_wdata  <= 32'd0;
            r_load_data  <= 32'd0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_funct3    <= req_funct3;
                        r_offset    <= req_addr[1:0];
                        r_req_ready <= 1'b0;
                        if (w_fault) begin
                            r_state      <= S_FAULT;
                            r_misaligned <= 1'b1;
                        end else begin
                            r_state     <= S_WAIT;
                            r_cnt       <= 8'd0;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= req_write;
                            r_mem_addr  <= {req_addr[31:2], 2'b00};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        if (!r_write) begin
                            r_load_data <= w_load_ext;
                        end
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= 32'd0;
                        r_mem_be    <= 4'd0;
                        r_mem_wdata <= 32'd0;
                    end else if (LP_TIMEOUT_EN && (r_cnt == LP_LAST_CNT)) begin
                        r_state     <= S_FAULT;
                        r_bus_error <= 1'b1;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= 32'd0;
                        r_mem_be    <= 4'd0;
                        r_mem_wdata <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    // DONE and FAULT each last exactly one cycle.
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_be     = r_mem_be;
    assign mem_wdata  = r_mem_wdata;
    assign load_data  = r_load_data;
    assign done       = r_done;
    assign misaligned = r_misaligned;
    assign bus_error  = r_bus_error;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage between the multicycle control FSM/ALU and the shared instruction/data memory. It accepts one load or store request per transaction, using the ALU result as the address and rs2 as store data. It drives a word-aligned memory port with byte enables and waits a variable number of cycles for acknowledge. For loads, it returns a registered, lane-extracted, sign/zero-extended word that feeds the `RESULT_SRC__DATA` leg of the result mux.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 255: maximum number of cycles to wait for `mem_ack` in WAIT. 0 disables the timeout. Counter width is 8 bits, so legal values are 0..255.

Ports:
- `clk`  in  1  system clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request strobe from control FSM; sampled only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- `req_addr`  in  32  byte address (ALU out).
- `req_wdata`  in  32  store data (rs2).
- `req_ready`  out  1  high while in IDLE.
- `mem_req`  out  1  memory request, held high through WAIT.
- `mem_we`  out  1  write enable, valid while `mem_req` is high.
- `mem_addr`  out  32  `{addr[31:2], 2'b00}`.
- `mem_be`  out  4  byte enables, bit i corresponds to `mem_wdata[8i+7:8i]`.
- `mem_wdata`  out  32  store data shifted to the addressed byte lane(s).
- `mem_ack`  in  1  memory completed the access; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  read word.
- `load_data`  out  32  registered extended load result.
- `done`  out  1  one-cycle pulse on successful completion.
- `misaligned`  out  1  one-cycle pulse on an alignment or encoding fault.
- `bus_error`  out  1  one-cycle pulse on ack timeout.

## Operation
- States: IDLE, WAIT, DONE, FAULT. The state is encoded in a 2-bit register.
- **IDLE.** `req_ready` is 1. On `req_valid`, capture `req_write`, `req_funct3`, `req_addr` and `req_wdata` into internal registers.
  - A fault goes to FAULT. A fault is any of: halfword access with `addr[0]` = 1; word access with `addr[1:0]` ≠ 0; load funct3 ∈ {011, 110, 111}; store funct3 ≥ 011.
  - Otherwise go to WAIT and load the timeout counter with 0.
- **WAIT.**
  - `mem_req` = 1. `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` come from the captured registers and are stable for the whole state.
  - On `mem_ack`: for loads, `load_data` ← ext(`mem_rdata`); then go to DONE.
  - Otherwise the counter increments. If `ACK_TIMEOUT` ≠ 0 and the counter reaches `ACK_TIMEOUT` − 1 without ack, go to FAULT with the error flagged as a bus error. `load_data` is not updated.
- **DONE.** `done` = 1 for one cycle, then go to IDLE.
- **FAULT.** Exactly one of `misaligned` or `bus_error` is 1 for one cycle, then go to IDLE. `mem_req` is never asserted for a misaligned request.
- Byte enables:
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `4'b0011 << addr[1:0]`.
  - Word: `4'b1111`.
  - Loads drive `mem_be = 4'b1111`.
- Store lanes: `mem_wdata = wdata << (8·addr[1:0])`. Unused lanes carry shifted data and are don't-care to memory.
- Load extraction: shift `mem_rdata` right by `8·addr[1:0]`, then extend.
  - LB / LH: sign-extend from bit 7 / bit 15.
  - LBU / LHU: zero-extend.
  - LW: pass through.
- `load_data` holds its value across stores, faults and idle cycles until the next successful load.

## Timing
- Reset values, all outputs: `req_ready` = 1 (state IDLE), `mem_req` = 0, `mem_we` = 0, `mem_be` = 0, `mem_addr` = 0, `mem_wdata` = 0, `load_data` = 0, `done` = 0, `misaligned` = 0, `bus_error` = 0.
- `req_valid` is ignored in any cycle where `reset` is high.
- Request accepted at edge N → `mem_req` high in cycle N+1.
  - Ack in cycle N+1 + k → `done` and the new `load_data` visible in cycle N+2 + k. Minimum request-to-done latency is 2 cycles.
  - The next request can be accepted in cycle N+3 + k.
- Fault path: accept at edge N → `misaligned` high in cycle N+1 → `req_ready` high in cycle N+2.
- `mem_ack` outside WAIT is ignored. `req_valid` outside IDLE is ignored, so the FSM must hold the request until `req_ready`.
- Reset mid-WAIT: the transaction is abandoned. `mem_req` is 0 in the cycle after the reset edge; no `done` and no `load_data` update.
- With `ACK_TIMEOUT` = 255 and no ack, `bus_error` pulses in the cycle after the 255th WAIT cycle.

## Test plan
- Reset, then SW with addr 0x100, wdata 0xDEADBEEF, ack after 3 wait cycles → `mem_addr` 0x100, `mem_be` 1111, `mem_we` 1, `mem_wdata` 0xDEADBEEF, `done` 5 cycles after accept, `load_data` stays 0.
- LB with addr 0x203, `mem_rdata` 0x80112233, immediate ack → `load_data` 0xFFFFFF80; repeated as LBU → 0x00000080.
- LH with addr 0x202, `mem_rdata` 0x8001_1234 → 0xFFFF8001; SH with addr 0x202, wdata 0x0000ABCD → `mem_be` 1100, `mem_wdata[31:16]` 0xABCD.
- LW with addr 0x102, and SH with addr 0x301 → `misaligned` pulse 1 cycle after accept, `mem_req` never asserted, `load_data` unchanged; same response for load funct3 011.
- `ACK_TIMEOUT` = 4, LW with no ack → `mem_req` high exactly 4 cycles, then one `bus_error` pulse, then IDLE; a subsequent LW with ack succeeds.
- Assert `reset` in the 2nd WAIT cycle of an LW → `mem_req` 0 in the next cycle, no `done`, `load_data` = 0, `req_ready` = 1.
